// File: rtl/rmii_pkg.sv
// Shared definitions for the RMII transmit arbiter: FSM state encoding,
// default timing constants, grant codes and small helper functions.
package rmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    // 96 bit times of inter-frame gap at 2 bits per REF_CLK cycle.
    localparam int IFG_CYCLES_DEF = 48;
    // Longest tolerated mid-frame starvation of the owning FIFO.
    localparam int STALL_MAX_DEF  = 1023;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_A    = 2'b01;
    localparam logic [1:0] GRANT_B    = 2'b10;

    // Width that holds the larger of the two counter limits without wrapping.
    function automatic int cnt_width(input int ifg, input int stall);
        int m;
        m = (ifg > stall) ? ifg : stall;
        return $clog2(m + 1);
    endfunction

    // One-hot grant {B,A} that belongs to a given arbiter state.
    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            ST_OWN_A: return GRANT_A;
            ST_OWN_B: return GRANT_B;
            default:  return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rmii_rr_pick.sv
// Two-way round-robin pick: given both ready flags and which port won last,
// returns the one-hot {B,A} winner (2'b00 when neither port is ready).
module rmii_rr_pick
    import rmii_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  logic       last_b,
    output logic [1:0] pick
);

    // A wins when alone or when B won the previous arbitration; otherwise B.
    always_comb begin
        pick = GRANT_NONE;
        if (req_a && (!req_b || last_b)) begin
            pick = GRANT_A;
        end else if (req_b) begin
            pick = GRANT_B;
        end
    end

endmodule

// File: rtl/rmii_tx_arbiter.sv
// Frame-level arbiter that merges two ingress FIFOs (A, B) onto the single
// FIFO-style interface read by RMII_TX. One whole frame is forwarded at a
// time, followed by an inter-frame gap; a starved owner is dropped after
// STALL_MAX empty cycles.
// Optional build macro RMII_ARB_FRAME_CNT_EN adds per-port 16-bit counters
// of completed frames (a_frame_cnt, b_frame_cnt).
module rmii_tx_arbiter
    import rmii_pkg::*;
#(
    parameter int IFG_CYCLES = IFG_CYCLES_DEF,
    parameter int STALL_MAX  = STALL_MAX_DEF
) (
    input  logic        REF_CLK,
    input  logic        arst_n,
    input  logic [7:0]  a_fifo_dout,
    input  logic        a_fifo_empty,
    input  logic        a_fifo_aempty,
    input  logic        a_fifo_EOD_out,
    output logic        a_fifo_rden,
    input  logic [7:0]  b_fifo_dout,
    input  logic        b_fifo_empty,
    input  logic        b_fifo_aempty,
    input  logic        b_fifo_EOD_out,
    output logic        b_fifo_rden,
    output logic [7:0]  tx_fifo_dout,
    output logic        tx_fifo_empty,
    output logic        tx_fifo_aempty,
    output logic        tx_fifo_EOD_out,
    input  logic        tx_fifo_rden,
`ifdef RMII_ARB_FRAME_CNT_EN
    output logic [15:0] a_frame_cnt,
    output logic [15:0] b_frame_cnt,
`endif
    output logic [1:0]  grant
);

    localparam int              CW         = cnt_width(IFG_CYCLES, STALL_MAX);
    localparam logic [CW-1:0]   IFG_LAST   = CW'(IFG_CYCLES - 1);
    localparam logic [CW-1:0]   STALL_LAST = CW'(STALL_MAX - 1);

    arb_state_t     state_q, state_d;
    logic [CW-1:0]  gap_q, gap_d;
    logic [CW-1:0]  stall_q, stall_d;
    logic           last_b_q, last_b_d;
    logic [1:0]     pick;
    logic           own_a, own_b;
    logic           frame_end;

    assign own_a     = (state_q == ST_OWN_A);
    assign own_b     = (state_q == ST_OWN_B);
    // Last byte of the frame leaves the owner FIFO in this cycle.
    assign frame_end = (own_a || own_b) && tx_fifo_rden && tx_fifo_EOD_out;

    rmii_rr_pick u_pick (
        .req_a  (!a_fifo_aempty),
        .req_b  (!b_fifo_aempty),
        .last_b (last_b_q),
        .pick   (pick)
    );

    // Datapath: pass the owner's FIFO through, present an idle FIFO otherwise.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no path can
        // leave one unassigned and infer a latch.
        tx_fifo_dout    = 8'h00;
        tx_fifo_empty   = 1'b1;
        tx_fifo_aempty  = 1'b1;
        tx_fifo_EOD_out = 1'b0;
        a_fifo_rden     = 1'b0;
        b_fifo_rden     = 1'b0;
        if (own_a) begin
            tx_fifo_dout    = a_fifo_dout;
            tx_fifo_empty   = a_fifo_empty;
            tx_fifo_aempty  = a_fifo_aempty;
            tx_fifo_EOD_out = a_fifo_EOD_out;
            a_fifo_rden     = tx_fifo_rden;
        end else if (own_b) begin
            tx_fifo_dout    = b_fifo_dout;
            tx_fifo_empty   = b_fifo_empty;
            tx_fifo_aempty  = b_fifo_aempty;
            tx_fifo_EOD_out = b_fifo_EOD_out;
            b_fifo_rden     = tx_fifo_rden;
        end
    end

    // Next-state logic: arbitration, frame end, stall abandon and gap timing.
    always_comb begin
        state_d  = state_q;
        gap_d    = '0;
        stall_d  = '0;
        last_b_d = last_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick == GRANT_A) begin
                    state_d  = ST_OWN_A;
                    last_b_d = 1'b0;
                end else if (pick == GRANT_B) begin
                    state_d  = ST_OWN_B;
                    last_b_d = 1'b1;
                end
            end
            ST_OWN_A, ST_OWN_B: begin
                if (frame_end) begin
                    state_d = ST_GAP;
                end else if (tx_fifo_empty) begin
                    // The STALL_MAX-th consecutive empty cycle is the last one owned.
                    if (stall_q == STALL_LAST) begin
                        state_d = ST_GAP;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, round-robin pointer and registered grant.
    always_ff @(posedge REF_CLK or negedge arst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!arst_n) begin
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            stall_q  <= '0;
            last_b_q <= 1'b1;
            grant    <= GRANT_NONE;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            stall_q  <= stall_d;
            last_b_q <= last_b_d;
            grant    <= grant_of(state_d);
        end
    end

`ifdef RMII_ARB_FRAME_CNT_EN
    // Completed-frame counters; abandoned frames never reach frame_end.
    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            a_frame_cnt <= '0;
            b_frame_cnt <= '0;
        end else begin
            if (frame_end && own_a) a_frame_cnt <= a_frame_cnt + 16'd1;
            if (frame_end && own_b) b_frame_cnt <= b_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// Self-checking bench for rmii_tx_arbiter: byte-queue FIFO sources, a
// frame-level reference model of ownership/gap/stall, directed scenarios
// with literal expectations, then randomized traffic.
module tb_rmii_tx_arbiter;
    import rmii_pkg::*;

    localparam int IFG   = IFG_CYCLES_DEF;
    localparam int STALL = STALL_MAX_DEF;

    logic        REF_CLK = 1'b0;
    logic        arst_n  = 1'b0;
    logic [7:0]  a_fifo_dout, b_fifo_dout, tx_fifo_dout;
    logic        a_fifo_empty, a_fifo_aempty, a_fifo_EOD_out, a_fifo_rden;
    logic        b_fifo_empty, b_fifo_aempty, b_fifo_EOD_out, b_fifo_rden;
    logic        tx_fifo_empty, tx_fifo_aempty, tx_fifo_EOD_out, tx_fifo_rden;
    logic [1:0]  grant;
`ifdef RMII_ARB_FRAME_CNT_EN
    logic [15:0] a_frame_cnt, b_frame_cnt;
`endif

    always #5 REF_CLK = ~REF_CLK;

    rmii_tx_arbiter #(.IFG_CYCLES(IFG), .STALL_MAX(STALL)) dut (
        .REF_CLK         (REF_CLK),
        .arst_n          (arst_n),
        .a_fifo_dout     (a_fifo_dout),
        .a_fifo_empty    (a_fifo_empty),
        .a_fifo_aempty   (a_fifo_aempty),
        .a_fifo_EOD_out  (a_fifo_EOD_out),
        .a_fifo_rden     (a_fifo_rden),
        .b_fifo_dout     (b_fifo_dout),
        .b_fifo_empty    (b_fifo_empty),
        .b_fifo_aempty   (b_fifo_aempty),
        .b_fifo_EOD_out  (b_fifo_EOD_out),
        .b_fifo_rden     (b_fifo_rden),
        .tx_fifo_dout    (tx_fifo_dout),
        .tx_fifo_empty   (tx_fifo_empty),
        .tx_fifo_aempty  (tx_fifo_aempty),
        .tx_fifo_EOD_out (tx_fifo_EOD_out),
        .tx_fifo_rden    (tx_fifo_rden),
`ifdef RMII_ARB_FRAME_CNT_EN
        .a_frame_cnt     (a_frame_cnt),
        .b_frame_cnt     (b_frame_cnt),
`endif
        .grant           (grant)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Ingress FIFO contents, each entry {eod, data}.
    logic [8:0] qa[$];
    logic [8:0] qb[$];

    // Reference model: owner 0=none 1=A 2=B; gap_left>0 means inter-frame gap.
    int m_owner, m_gap_left, m_stall, m_frames_a, m_frames_b;
    bit m_last_b;

    // Values seen at the latest falling edge.
    logic [1:0] obs_grant;
    logic       obs_a_rden, obs_a_empty;
    logic [15:0] obs_a_cnt, obs_b_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_fifos();
        logic [8:0] h;
        a_fifo_empty  = (qa.size() == 0);
        a_fifo_aempty = (qa.size() < 2);
        h = (qa.size() != 0) ? qa[0] : 9'h000;
        a_fifo_dout    = h[7:0];
        a_fifo_EOD_out = h[8];
        b_fifo_empty  = (qb.size() == 0);
        b_fifo_aempty = (qb.size() < 2);
        h = (qb.size() != 0) ? qb[0] : 9'h000;
        b_fifo_dout    = h[7:0];
        b_fifo_EOD_out = h[8];
    endtask

    task automatic push_frame(input int port, input int len, input bit with_eod);
        logic [8:0] e;
        for (int i = 0; i < len; i++) begin
            e = {(with_eod && (i == len - 1)), 8'($urandom)};
            if (port == 0) qa.push_back(e);
            else           qb.push_back(e);
        end
        drive_fifos();
    endtask

    task automatic model_reset();
        m_owner = 0; m_gap_left = 0; m_stall = 0; m_last_b = 1'b1;
        m_frames_a = 0; m_frames_b = 0;
        qa.delete(); qb.delete();
        drive_fifos();
    endtask

    // Advance the model over one rising edge using the inputs the DUT sampled.
    task automatic model_step();
        bit ra, rb, o_empty, o_eod, ended;
        if (!arst_n) return;
        if (m_owner == 0) begin
            if (m_gap_left > 0) begin
                m_gap_left--;
            end else begin
                ra = !a_fifo_aempty;
                rb = !b_fifo_aempty;
                if (ra && (!rb || m_last_b)) begin
                    m_owner = 1; m_last_b = 1'b0;
                end else if (rb) begin
                    m_owner = 2; m_last_b = 1'b1;
                end
            end
        end else begin
            o_empty = (m_owner == 1) ? a_fifo_empty   : b_fifo_empty;
            o_eod   = (m_owner == 1) ? a_fifo_EOD_out : b_fifo_EOD_out;
            ended   = tx_fifo_rden && o_eod;
            if (tx_fifo_rden && !o_empty) begin
                if (m_owner == 1) void'(qa.pop_front());
                else              void'(qb.pop_front());
            end
            if (ended) begin
                if (m_owner == 1) m_frames_a++;
                else              m_frames_b++;
                m_owner = 0; m_gap_left = IFG; m_stall = 0;
            end else if (o_empty) begin
                m_stall++;
                if (m_stall == STALL) begin
                    m_owner = 0; m_gap_left = IFG; m_stall = 0;
                end
            end else begin
                m_stall = 0;
            end
        end
    endtask

    // Compare every DUT output with what the model says it must be.
    task automatic compare_outputs();
        logic [14:0] act, exp;
        act = {grant, tx_fifo_dout, tx_fifo_empty, tx_fifo_aempty, tx_fifo_EOD_out,
               a_fifo_rden, b_fifo_rden};
        if (m_owner == 1)
            exp = {GRANT_A, a_fifo_dout, a_fifo_empty, a_fifo_aempty, a_fifo_EOD_out,
                   tx_fifo_rden, 1'b0};
        else if (m_owner == 2)
            exp = {GRANT_B, b_fifo_dout, b_fifo_empty, b_fifo_aempty, b_fifo_EOD_out,
                   1'b0, tx_fifo_rden};
        else
            exp = {GRANT_NONE, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        check("outputs{grant,dout,empty,aempty,eod,a_rden,b_rden}", 32'(act), 32'(exp));
`ifdef RMII_ARB_FRAME_CNT_EN
        check("a_frame_cnt", 32'(a_frame_cnt), 32'(m_frames_a & 16'hFFFF));
        check("b_frame_cnt", 32'(b_frame_cnt), 32'(m_frames_b & 16'hFFFF));
        obs_a_cnt = a_frame_cnt;
        obs_b_cnt = b_frame_cnt;
`else
        obs_a_cnt = 16'(m_frames_a);
        obs_b_cnt = 16'(m_frames_b);
`endif
        obs_grant   = grant;
        obs_a_rden  = a_fifo_rden;
        obs_a_empty = a_fifo_empty;
    endtask

    // One clock: compare at the falling edge, step the model at the rising edge.
    task automatic cycle();
        @(negedge REF_CLK);
        compare_outputs();
        @(posedge REF_CLK);
        model_step();
        cyc++;
        #1;
        drive_fifos();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, own, k, bound;
        int grants[$];
        int exp_seq[5];
        logic [1:0] prev;

        tx_fifo_rden = 1'b0;
        model_reset();
        arst_n = 1'b0;
        repeat (3) cycle();
        check("reset_grant", 32'(obs_grant), 32'(2'b00));
        check("reset_tx_empty", 32'(tx_fifo_empty), 32'(1'b1));
        arst_n = 1'b1;

        // A-only frame of 5 bytes, RMII_TX reading continuously.
        tx_fifo_rden = 1'b1;
        repeat (10) cycle();
        push_frame(0, 5, 1'b1);
        cycle();
        check("a_only_idle_cycle_grant", 32'(obs_grant), 32'(GRANT_NONE));
        cycle();
        check("a_only_grant_next_cycle", 32'(obs_grant), 32'(GRANT_A));
        pulses = 0; own = 0;
        while (obs_grant == GRANT_A && own < 100) begin
            own++;
            if (obs_a_rden) pulses++;
            cycle();
        end
        check("a_only_rden_pulses", 32'(pulses), 32'd5);
        check("a_only_owned_cycles", 32'(own), 32'd5);

        // B becomes ready during A's gap; it must wait out the whole gap.
        // k counts cycles from the first gap cycle (k=0).
        k = 0;
        while (obs_grant == GRANT_NONE && k < 200) begin
            if (k == 10) push_frame(1, 4, 1'b1);
            cycle();
            k++;
        end
        check("b_grant_cycles_after_gap_start", 32'(k), 32'(IFG + 1));
        check("b_grant_value", 32'(obs_grant), 32'(GRANT_B));
        bound = 0;
        while (obs_grant != GRANT_NONE && bound < 200) begin cycle(); bound++; end

        // Reset in the middle of an A frame.
        push_frame(0, 8, 1'b1);
        bound = 0;
        while (obs_grant != GRANT_A && bound < 200) begin cycle(); bound++; end
        repeat (2) cycle();
        arst_n = 1'b0;
        #1;
        check("rst_now_grant", 32'(grant), 32'(2'b00));
        check("rst_now_tx_empty", 32'(tx_fifo_empty), 32'(1'b1));
        check("rst_now_rden", 32'({a_fifo_rden, b_fifo_rden}), 32'(2'b00));
        model_reset();
        repeat (2) cycle();
        arst_n = 1'b1;

        // Three A and two B frames all ready together: strict alternation, A first.
        push_frame(0, 3, 1'b1); push_frame(0, 4, 1'b1); push_frame(0, 5, 1'b1);
        push_frame(1, 2, 1'b1); push_frame(1, 6, 1'b1);
        exp_seq = '{1, 2, 1, 2, 1};
        prev = GRANT_NONE; bound = 0;
        while (grants.size() < 5 && bound < 2000) begin
            cycle(); bound++;
            if (obs_grant != GRANT_NONE && prev == GRANT_NONE) grants.push_back(int'(obs_grant));
            prev = obs_grant;
        end
        check("rr_grant_count", 32'(grants.size()), 32'd5);
        foreach (grants[i]) check($sformatf("rr_order_%0d", i), 32'(grants[i]), 32'(exp_seq[i]));
        bound = 0;
        while (obs_grant != GRANT_NONE && bound < 200) begin cycle(); bound++; end
        check("frames_a_after_rr", 32'(obs_a_cnt), 32'd3);
        check("frames_b_after_rr", 32'(obs_b_cnt), 32'd2);

        // Owner starvation: two bytes without EOD, then the FIFO runs dry.
        push_frame(0, 2, 1'b0);
        bound = 0;
        while (obs_grant != GRANT_A && bound < 200) begin cycle(); bound++; end
        k = 0; bound = 0;
        while (obs_grant == GRANT_A && bound < 5000) begin
            if (obs_a_empty) k++;
            cycle(); bound++;
        end
        check("stall_empty_cycles", 32'(k), 32'(STALL));
        check("stall_release_grant", 32'(obs_grant), 32'(GRANT_NONE));
        check("stall_frames_a_unchanged", 32'(obs_a_cnt), 32'd3);

        // Randomized traffic, including reads while no port is owned.
        repeat (4000) begin
            cycle();
            tx_fifo_rden = ($urandom_range(0, 3) != 0);
            if (qa.size() < 40 && $urandom_range(0, 19) == 0)
                push_frame(0, $urandom_range(2, 8), 1'b1);
            if (qb.size() < 40 && $urandom_range(0, 19) == 0)
                push_frame(1, $urandom_range(2, 8), 1'b1);
        end

        // Drain everything that is still queued.
        tx_fifo_rden = 1'b1;
        bound = 0;
        while ((qa.size() != 0 || qb.size() != 0 || m_owner != 0 || m_gap_left != 0)
               && bound < 3000) begin
            cycle(); bound++;
        end
        check("drain_bytes_left", 32'(qa.size() + qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
